store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: DEPTH, 8, number of store entries; power of two, 2..32.
REQ-002 Port: clk  in  1  sole clock, all state on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset.
REQ-004 Port: exception  in  1  pipeline flush, synchronous, active-high.
REQ-005 Port: store_valid  in  1  issue stage presents a resolved store.
REQ-006 Port: store_address / store_data / store_inst_num  in  32 each  store word address, data, program-order tag.
REQ-007 Port: store_ready  out  1  high when the buffer can accept a store (not full).
REQ-008 Port: memwrite  out  1  one-cycle pulse to load buffer: store address resolved.
REQ-009 Port: out_store_address / out_store_inst_num  out  32 each  address and tag qualified by memwrite.
REQ-010 Port: commit_valid, commit_inst_num  in  1, 32  ROB retires store with this tag.
REQ-011 Port: dmem_we  out  1; dmem_addr, dmem_wdata  out  32 each  data-memory write request.
REQ-012 Port: dmem_ready  in  1  data memory accepts the write this cycle.
REQ-013 Port: fwd_addr, fwd_inst_num  in  32 each  load lookup address and tag.
REQ-014 Port: fwd_hit  out  1; fwd_data  out  32  forwarding result.
REQ-015 Port: count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-016 Circular FIFO, head/tail pointers of $clog2(DEPTH) bits with wrap; one extra bit each distinguishes full from empty.
REQ-017 Entry states: FREE, PENDING, COMMITTED; FREE->PENDING on accept, PENDING->COMMITTED on matching commit, COMMITTED->FREE on drain.
REQ-018 Accept when store_valid && store_ready && !exception: write at tail, state PENDING, tail+1.
REQ-019 Registered broadcast: memwrite=1 exactly the cycle after accept, with the accepted address/tag; otherwise memwrite=0, address/tag hold.
REQ-020 Commit: entry whose state is PENDING and tag equals commit_inst_num becomes COMMITTED the next edge; no match is ignored, no error.
REQ-021 Drain: dmem_we = (head entry COMMITTED), combinational from state; dmem_addr/wdata = head entry; on dmem_we && dmem_ready head frees, head+1.
REQ-022 Forwarding is combinational: fwd_hit=1 if any non-FREE entry has address==fwd_addr and tag<fwd_inst_num; fwd_data from the youngest such entry (nearest tail); else fwd_hit=0, fwd_data=0.
REQ-023 store_ready = !full; a drain in the same cycle does not free space for a same-cycle accept.
REQ-024 Accept and drain in one cycle: both occur, count unchanged.
REQ-025 exception: all PENDING entries freed next edge, tail <= head + COMMITTED count; COMMITTED entries still drain; memwrite forced 0 next cycle.
REQ-026 exception with commit_valid same cycle: commit applied first, that entry survives the flush.
REQ-027 exception with store_valid same cycle: store dropped, no memwrite.

Reset
REQ-028 reset low: all entries FREE, head=tail=0, count=0, store_ready=1; memwrite, dmem_we, fwd_hit=0; all 32-bit outputs 0.
REQ-029 Reset asserted mid-drain aborts the write immediately; dmem_we drops asynchronously.

Structure
REQ-030 Shared package holds DEPTH default, pointer width, entry-state encoding (FREE/PENDING/COMMITTED) and 32-bit tag/address widths.
REQ-031 One sub-module, sb_fwd_match: combinational youngest-older-match priority selector for forwarding.

Verification
REQ-032 Accept store addr 0x100, data 0xAA, tag 5 -> next cycle memwrite=1, out_store_address=0x100, out_store_inst_num=5; count=1.
REQ-033 Fill 8 stores -> store_ready=0; further store_valid ignored; commit tag of head with dmem_ready=1 -> dmem_we with head data, store_ready=1 following cycle.
REQ-034 Stores 0x200/tag 3 data 0x11 and 0x200/tag 7 data 0x22; lookup 0x200 tag 9 -> hit, 0x22; tag 5 -> hit, 0x11; tag 2 -> no hit.
REQ-035 Entries tags 1(COMMITTED),2,3 (PENDING); exception -> count=1, only tag 1 drains; commit tag 2 with exception same cycle -> count=2.
REQ-036 Wrap: 20 accept/drain cycles with DEPTH=8 -> FIFO order preserved across pointer wrap; reset low mid-operation -> all outputs to REQ-028 values without clock.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and widths for the store buffer: entry-state encoding, pointer
// width and the per-entry storage record.
package store_buffer_pkg;
  localparam int SB_DEPTH  = 8;
  localparam int SB_PTR_W  = $clog2(SB_DEPTH);
  localparam int SB_ADDR_W = 32;
  localparam int SB_TAG_W  = 32;

  typedef enum logic [1:0] {
    SB_FREE      = 2'd0,
    SB_PENDING   = 2'd1,
    SB_COMMITTED = 2'd2
  } sb_state_e;

  typedef struct packed {
    sb_state_e              st;
    logic [SB_ADDR_W-1:0]   addr;
    logic [SB_ADDR_W-1:0]   data;
    logic [SB_TAG_W-1:0]    tag;
  } sb_entry_t;
endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding selector: among occupied entries with a matching
// address and an older tag, returns the data of the youngest one.
module sb_fwd_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]                busy,
  input  logic [DEPTH-1:0][SB_ADDR_W-1:0] e_addr,
  input  logic [DEPTH-1:0][SB_ADDR_W-1:0] e_data,
  input  logic [DEPTH-1:0][SB_TAG_W-1:0]  e_tag,
  input  logic [PTR_W-1:0]                head_idx,
  input  logic [SB_ADDR_W-1:0]            fwd_addr,
  input  logic [SB_TAG_W-1:0]             fwd_inst_num,
  output logic                            fwd_hit,
  output logic [SB_ADDR_W-1:0]            fwd_data
);
  logic [DEPTH-1:0] match;
  logic [PTR_W-1:0] idx;

  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    assign match[g] = busy[g] && (e_addr[g] == fwd_addr) && (e_tag[g] < fwd_inst_num);
  end

  // Walk oldest to youngest from head so the last hit seen is the youngest.
  always_comb begin
    fwd_hit  = |match;
    fwd_data = '0;
    idx      = head_idx;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_idx + k[PTR_W-1:0];
      if (match[idx]) fwd_data = e_data[idx];
    end
  end
endmodule

// File: rtl/store_buffer.sv
// Circular store buffer: holds resolved stores until the ROB commits them,
// drains committed stores in order to data memory, and forwards to loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     exception,
  input  logic                     store_valid,
  input  logic [31:0]              store_address,
  input  logic [31:0]              store_data,
  input  logic [31:0]              store_inst_num,
  output logic                     store_ready,
  output logic                     memwrite,
  output logic [31:0]              out_store_address,
  output logic [31:0]              out_store_inst_num,
  input  logic                     commit_valid,
  input  logic [31:0]              commit_inst_num,
  output logic                     dmem_we,
  output logic [31:0]              dmem_addr,
  output logic [31:0]              dmem_wdata,
  input  logic                     dmem_ready,
  input  logic [31:0]              fwd_addr,
  input  logic [31:0]              fwd_inst_num,
  output logic                     fwd_hit,
  output logic [31:0]              fwd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  sb_entry_t [DEPTH-1:0] ent;
  sb_state_e             st_nxt [DEPTH];
  logic [PTR_W:0]        head, tail, head_nxt, tail_nxt, n_comm;
  logic [PTR_W-1:0]      head_idx, tail_idx;
  logic                  full, acc, drain;

  logic [DEPTH-1:0]                busy;
  logic [DEPTH-1:0][SB_ADDR_W-1:0] e_addr, e_data;
  logic [DEPTH-1:0][SB_TAG_W-1:0]  e_tag;

  assign head_idx    = head[PTR_W-1:0];
  assign tail_idx    = tail[PTR_W-1:0];
  assign count       = tail - head;
  assign full        = count[PTR_W];
  assign store_ready = !full;
  assign acc         = store_valid && !full && !exception;
  assign dmem_we     = (ent[head_idx].st == SB_COMMITTED);
  assign dmem_addr   = ent[head_idx].addr;
  assign dmem_wdata  = ent[head_idx].data;
  assign drain       = dmem_we && dmem_ready;

  // Commit is applied before the flush so a same-cycle commit survives it.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) st_nxt[i] = ent[i].st;
    for (int i = 0; i < DEPTH; i++)
      if (commit_valid && ent[i].st == SB_PENDING && ent[i].tag == commit_inst_num)
        st_nxt[i] = SB_COMMITTED;
    if (drain) st_nxt[head_idx] = SB_FREE;
    if (exception) begin
      for (int i = 0; i < DEPTH; i++)
        if (st_nxt[i] == SB_PENDING) st_nxt[i] = SB_FREE;
    end else if (acc) begin
      st_nxt[tail_idx] = SB_PENDING;
    end
    n_comm = '0;
    for (int i = 0; i < DEPTH; i++)
      if (st_nxt[i] == SB_COMMITTED) n_comm = n_comm + 1'b1;
    head_nxt = head + {{PTR_W{1'b0}}, drain};
    // Committed entries are always the oldest, so they sit contiguously at head.
    tail_nxt = exception ? head_nxt + n_comm : tail + {{PTR_W{1'b0}}, acc};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent                <= '0;
      head               <= '0;
      tail               <= '0;
      memwrite           <= 1'b0;
      out_store_address  <= '0;
      out_store_inst_num <= '0;
    end else begin
      head     <= head_nxt;
      tail     <= tail_nxt;
      memwrite <= acc;
      for (int i = 0; i < DEPTH; i++) ent[i].st <= st_nxt[i];
      if (acc) begin
        ent[tail_idx].addr <= store_address;
        ent[tail_idx].data <= store_data;
        ent[tail_idx].tag  <= store_inst_num;
        out_store_address  <= store_address;
        out_store_inst_num <= store_inst_num;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      busy[i]   = (ent[i].st != SB_FREE);
      e_addr[i] = ent[i].addr;
      e_data[i] = ent[i].data;
      e_tag[i]  = ent[i].tag;
    end
  end

  sb_fwd_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd (
    .busy         (busy),
    .e_addr       (e_addr),
    .e_data       (e_data),
    .e_tag        (e_tag),
    .head_idx     (head_idx),
    .fwd_addr     (fwd_addr),
    .fwd_inst_num (fwd_inst_num),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data)
  );
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: accept/broadcast, full handling, drain,
// forwarding priority, flush behaviour, pointer wrap and async reset.
module tb_store_buffer;
  localparam int DEPTH = 8;

  logic        clk = 1'b0, reset = 1'b0, exception = 1'b0;
  logic        store_valid = 1'b0;
  logic [31:0] store_address = '0, store_data = '0, store_inst_num = '0;
  logic        store_ready, memwrite;
  logic [31:0] out_store_address, out_store_inst_num;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_inst_num = '0;
  logic        dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready = 1'b0;
  logic [31:0] fwd_addr = '0, fwd_inst_num = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [3:0]  count;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .exception(exception),
    .store_valid(store_valid), .store_address(store_address),
    .store_data(store_data), .store_inst_num(store_inst_num),
    .store_ready(store_ready), .memwrite(memwrite),
    .out_store_address(out_store_address), .out_store_inst_num(out_store_inst_num),
    .commit_valid(commit_valid), .commit_inst_num(commit_inst_num),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .fwd_addr(fwd_addr), .fwd_inst_num(fwd_inst_num),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    exception = 1'b0; store_valid = 1'b0; commit_valid = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [31:0] t);
    store_valid = 1'b1; store_address = a; store_data = d; store_inst_num = t;
  endtask

  task automatic commit(input logic [31:0] t);
    commit_valid = 1'b1; commit_inst_num = t;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    #1;
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
    n_cmp++; if (store_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", store_ready); end
    n_cmp++; if ({memwrite, dmem_we, fwd_hit} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {memwrite, dmem_we, fwd_hit}); end
    n_cmp++; if ({out_store_address, out_store_inst_num, dmem_addr, dmem_wdata, fwd_data} !== 160'd0) begin
      n_err++; $display("FAIL reset_buses got nonzero want 0"); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_accept();
    do_reset();
    push(32'h100, 32'hAA, 32'd5);
    tick();
    store_valid = 1'b0;
    n_cmp++; if (memwrite !== 1'b1) begin n_err++; $display("FAIL accept_memwrite got %b want 1", memwrite); end
    n_cmp++; if (out_store_address !== 32'h100) begin n_err++; $display("FAIL accept_addr got %h want 100", out_store_address); end
    n_cmp++; if (out_store_inst_num !== 32'd5) begin n_err++; $display("FAIL accept_tag got %0d want 5", out_store_inst_num); end
    n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL accept_count got %0d want 1", count); end
    tick();
    n_cmp++; if (memwrite !== 1'b0) begin n_err++; $display("FAIL accept_pulse got %b want 0", memwrite); end
    n_cmp++; if (out_store_address !== 32'h100) begin n_err++; $display("FAIL accept_hold got %h want 100", out_store_address); end
    n_cmp++; if (dmem_we !== 1'b0) begin n_err++; $display("FAIL accept_nodrain got %b want 0", dmem_we); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push(32'h300 + i, 32'hD0 + i, 32'd10 + i);
      tick();
    end
    push(32'h399, 32'h99, 32'd99);
    n_cmp++; if (store_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", store_ready); end
    tick();
    store_valid = 1'b0;
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL full_count got %0d want 8", count); end
    n_cmp++; if (memwrite !== 1'b0) begin n_err++; $display("FAIL full_ignored got %b want 0", memwrite); end
    commit(32'd10);
    tick();
    commit_valid = 1'b0;
    n_cmp++; if (dmem_we !== 1'b1) begin n_err++; $display("FAIL full_dmem_we got %b want 1", dmem_we); end
    n_cmp++; if (dmem_addr !== 32'h300 || dmem_wdata !== 32'hD0) begin
      n_err++; $display("FAIL full_head got %h/%h want 300/d0", dmem_addr, dmem_wdata); end
    // drain and store in the same full cycle: store must be refused
    dmem_ready = 1'b1;
    push(32'h350, 32'h55, 32'd50);
    tick();
    idle();
    n_cmp++; if (count !== 4'd7 || store_ready !== 1'b1) begin
      n_err++; $display("FAIL full_drain got count %0d ready %b want 7 1", count, store_ready); end
    n_cmp++; if (memwrite !== 1'b0) begin n_err++; $display("FAIL full_same_cycle got %b want 0", memwrite); end
    n_cmp++; if (dmem_we !== 1'b0) begin n_err++; $display("FAIL full_next_pending got %b want 0", dmem_we); end
    commit(32'd11);
    tick();
    commit_valid = 1'b0;
    dmem_ready = 1'b1;
    push(32'h360, 32'h66, 32'd60);
    tick();
    idle();
    n_cmp++; if (count !== 4'd7) begin n_err++; $display("FAIL acc_drain_count got %0d want 7", count); end
    n_cmp++; if (memwrite !== 1'b1 || out_store_inst_num !== 32'd60) begin
      n_err++; $display("FAIL acc_drain_bcast got %b/%0d want 1/60", memwrite, out_store_inst_num); end
  endtask

  task automatic test_forward();
    do_reset();
    push(32'h200, 32'h11, 32'd3); tick();
    push(32'h204, 32'h33, 32'd4); tick();
    push(32'h200, 32'h22, 32'd7); tick();
    store_valid = 1'b0;
    fwd_addr = 32'h200; fwd_inst_num = 32'd9; #1;
    n_cmp++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin n_err++; $display("FAIL fwd_t9 got %b/%h want 1/22", fwd_hit, fwd_data); end
    fwd_inst_num = 32'd5; #1;
    n_cmp++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h11) begin n_err++; $display("FAIL fwd_t5 got %b/%h want 1/11", fwd_hit, fwd_data); end
    fwd_inst_num = 32'd7; #1;
    n_cmp++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h11) begin n_err++; $display("FAIL fwd_t7 got %b/%h want 1/11", fwd_hit, fwd_data); end
    fwd_inst_num = 32'd2; #1;
    n_cmp++; if (fwd_hit !== 1'b0 || fwd_data !== 32'h0) begin n_err++; $display("FAIL fwd_t2 got %b/%h want 0/0", fwd_hit, fwd_data); end
    fwd_addr = 32'h208; fwd_inst_num = 32'd9; #1;
    n_cmp++; if (fwd_hit !== 1'b0) begin n_err++; $display("FAIL fwd_addr_miss got %b want 0", fwd_hit); end
    fwd_addr = 32'h0; fwd_inst_num = 32'h0;
  endtask

  task automatic test_exception();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(32'h400 + i, 32'hE1 + i, 32'd1 + i); tick();
    end
    store_valid = 1'b0;
    commit(32'd1); tick(); commit_valid = 1'b0;
    exception = 1'b1;
    push(32'h4FF, 32'hFF, 32'd4);
    tick();
    idle();
    n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL exc_count got %0d want 1", count); end
    n_cmp++; if (memwrite !== 1'b0) begin n_err++; $display("FAIL exc_memwrite got %b want 0", memwrite); end
    n_cmp++; if (dmem_we !== 1'b1 || dmem_addr !== 32'h400) begin n_err++; $display("FAIL exc_drain got %b/%h want 1/400", dmem_we, dmem_addr); end
    dmem_ready = 1'b1; tick(); dmem_ready = 1'b0;
    n_cmp++; if (count !== 4'd0 || dmem_we !== 1'b0) begin n_err++; $display("FAIL exc_empty got %0d/%b want 0/0", count, dmem_we); end

    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(32'h400 + i, 32'hE1 + i, 32'd1 + i); tick();
    end
    store_valid = 1'b0;
    commit(32'd1); tick();
    commit(32'd2); exception = 1'b1; tick();
    idle();
    n_cmp++; if (count !== 4'd2) begin n_err++; $display("FAIL exc_commit_count got %0d want 2", count); end
    dmem_ready = 1'b1; tick();
    n_cmp++; if (dmem_we !== 1'b1 || dmem_wdata !== 32'hE2) begin n_err++; $display("FAIL exc_commit_second got %b/%h want 1/e2", dmem_we, dmem_wdata); end
    tick(); dmem_ready = 1'b0;
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL exc_commit_empty got %0d want 0", count); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(32'h500 + i, 32'h1000 + i, 32'd100 + i); tick();
    end
    store_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      commit(32'd100 + i); tick(); commit_valid = 1'b0;
      n_cmp++; if (dmem_we !== 1'b1 || dmem_wdata !== 32'h1000 + i) begin
        n_err++; $display("FAIL wrap_order[%0d] got %b/%h want 1/%h", i, dmem_we, dmem_wdata, 32'h1000 + i); end
      dmem_ready = 1'b1;
      push(32'h500 + i + 3, 32'h1000 + i + 3, 32'd103 + i);
      tick();
      idle();
      n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL wrap_count[%0d] got %0d want 3", i, count); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    push(32'h600, 32'h77, 32'd1); tick();
    store_valid = 1'b0;
    commit(32'd1); tick(); commit_valid = 1'b0;
    fwd_addr = 32'h600; fwd_inst_num = 32'd9;
    #2;
    n_cmp++; if (dmem_we !== 1'b1 || fwd_hit !== 1'b1) begin n_err++; $display("FAIL arst_pre got %b/%b want 1/1", dmem_we, fwd_hit); end
    reset = 1'b0;
    #1;
    n_cmp++; if (dmem_we !== 1'b0 || fwd_hit !== 1'b0 || memwrite !== 1'b0) begin
      n_err++; $display("FAIL arst_flags got %b%b%b want 000", dmem_we, fwd_hit, memwrite); end
    n_cmp++; if (count !== 4'd0 || store_ready !== 1'b1) begin n_err++; $display("FAIL arst_count got %0d/%b want 0/1", count, store_ready); end
    n_cmp++; if ({out_store_address, out_store_inst_num, dmem_addr, dmem_wdata, fwd_data} !== 160'd0) begin
      n_err++; $display("FAIL arst_buses got nonzero want 0"); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_accept();
    test_full();
    test_forward();
    test_exception();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
